roll_history: RTL and testbench

ROLL_HISTORY -- requirements
Module: roll_history

---
 rtl/roll_history_if.sv | 26 ++
 rtl/roll_history.sv | 126 ++++++++++++
 tb/tb_roll_history.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/roll_history_if.sv
// Bus bundle for the roll history display block.
// Carries the roll strobe/value, the browse and clear pulses, and the display outputs.
interface roll_history_if;
  logic       i_valid;
  logic [3:0] i_value;
  logic       i_prev;
  logic       i_next;
  logic       i_clear;
  logic [3:0] o_value;
  logic [3:0] o_index;
  logic [4:0] o_count;
  logic       o_empty;
  logic       o_browsing;

  // Producer side: the roll generator and the user buttons.
  modport master (
    output i_valid, i_value, i_prev, i_next, i_clear,
    input  o_value, o_index, o_count, o_empty, o_browsing
  );

  // History block side.
  modport slave (
    input  i_valid, i_value, i_prev, i_next, i_clear,
    output o_value, o_index, o_count, o_empty, o_browsing
  );
endinterface

// File: rtl/roll_history.sv
// Rolling history of the last DEPTH dice results with a browse cursor.
// The results are kept in a circular buffer. The newest entry is shown
// live; prev/next pulses step through older entries. A new roll always
// snaps the display back to the live view.
module roll_history #(
  parameter int DEPTH = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  roll_history_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  // Reject unsupported depths at elaboration time.
  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("roll_history: DEPTH must be a power of two in 2..16");
  end

  typedef enum logic {
    S_LIVE   = 1'b0,
    S_BROWSE = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] w_wp_next;
  logic [4:0]    r_cnt;
  logic [4:0]    w_cnt_next;
  logic [3:0]    r_index;
  logic [3:0]    w_index_next;
  logic [3:0]    r_value;
  logic [3:0]    w_value_next;
  logic          w_wr_en;
  logic [AW-1:0] w_rd_addr;

  // Next-state logic. Priority is clear > valid > prev > next, and only
  // the winning event of a cycle has any effect.
  always_comb begin
    w_state_next = r_state;
    w_wp_next    = r_wp;
    w_cnt_next   = r_cnt;
    w_index_next = r_index;
    w_wr_en      = 1'b0;
    w_value_next = 4'd0;
    w_rd_addr    = '0;

    if (bus.i_clear) begin
      w_state_next = S_LIVE;
      w_wp_next    = '0;
      w_cnt_next   = 5'd0;
      w_index_next = 4'd0;
    end else if (bus.i_valid) begin
      w_wr_en      = 1'b1;
      w_wp_next    = r_wp + AW'(1);
      w_cnt_next   = (r_cnt == 5'(DEPTH)) ? r_cnt : r_cnt + 5'd1;
      w_index_next = 4'd0;
      w_state_next = S_LIVE;
    end else if (bus.i_prev) begin
      if (r_state == S_LIVE) begin
        // With fewer than two entries there is nothing older to show.
        if (r_cnt >= 5'd2) begin
          w_state_next = S_BROWSE;
          w_index_next = 4'd1;
        end
      end else if ({1'b0, r_index} < (r_cnt - 5'd1)) begin
        // The cursor stops at the oldest entry; it never wraps.
        w_index_next = r_index + 4'd1;
      end
    end else if (bus.i_next) begin
      if (r_state == S_BROWSE) begin
        w_index_next = r_index - 4'd1;
        if (r_index == 4'd1) begin
          w_state_next = S_LIVE;
        end
      end
    end

    // Age k is stored at (wp-1-k); the wrap happens naturally in AW bits.
    w_rd_addr = r_wp - AW'(1) - w_index_next[AW-1:0];

    // A fresh roll is shown directly, since it is not in the buffer until this edge.
    if (bus.i_clear) begin
      w_value_next = 4'd0;
    end else if (bus.i_valid) begin
      w_value_next = bus.i_value;
    end else if (w_cnt_next == 5'd0) begin
      w_value_next = 4'd0;
    end else begin
      w_value_next = r_mem[w_rd_addr];
    end
  end

  // Control and display registers. Reset takes effect without waiting for a clock edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_LIVE;
      r_wp    <= '0;
      r_cnt   <= 5'd0;
      r_index <= 4'd0;
      r_value <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_wp    <= w_wp_next;
      r_cnt   <= w_cnt_next;
      r_index <= w_index_next;
      r_value <= w_value_next;
    end
  end

  // Result storage. It has no reset because r_cnt already marks which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wp] <= bus.i_value;
    end
  end

  assign bus.o_value    = r_value;
  assign bus.o_index    = r_index;
  assign bus.o_count    = r_cnt;
  assign bus.o_empty    = (r_cnt == 5'd0);
  assign bus.o_browsing = (r_state == S_BROWSE);

endmodule

// File: tb/tb_roll_history.sv
// Testbench for roll_history. It runs directed steps and then random
// cycles. The expected outputs come from a history queue (newest first)
// and a browse cursor.
module tb_roll_history;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  roll_history_if bus ();

  roll_history #(.DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int       n_vec = 0;
  int       n_err = 0;
  int       hist[$];
  int       m_idx = 0;
  bit       m_browse = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_idx    = 0;
    m_browse = 1'b0;
  endtask

  task automatic model_step(input bit v, input int val, input bit p, input bit n, input bit c);
    if (c) begin
      model_reset();
    end else if (v) begin
      hist.push_front(val);
      if (hist.size() > DEPTH) void'(hist.pop_back());
      m_idx    = 0;
      m_browse = 1'b0;
    end else if (p) begin
      if (!m_browse) begin
        if (hist.size() >= 2) begin
          m_browse = 1'b1;
          m_idx    = 1;
        end
      end else if (m_idx < hist.size() - 1) begin
        m_idx++;
      end
    end else if (n) begin
      if (m_browse) begin
        m_idx--;
        if (m_idx == 0) m_browse = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int exp_val;
    exp_val = (hist.size() == 0) ? 0 : hist[m_idx];
    chk({tag, ".value"},    32'(bus.o_value),    32'(exp_val));
    chk({tag, ".index"},    32'(bus.o_index),    32'(m_idx));
    chk({tag, ".count"},    32'(bus.o_count),    32'(hist.size()));
    chk({tag, ".empty"},    32'(bus.o_empty),    32'(hist.size() == 0));
    chk({tag, ".browsing"}, 32'(bus.o_browsing), 32'(m_browse));
  endtask

  // Drives one cycle of inputs, clocks it, updates the model and samples the outputs 1 ns after the edge.
  task automatic apply(input bit v, input int val, input bit p, input bit n, input bit c);
    @(negedge clk);
    bus.i_valid = v;
    bus.i_value = 4'(val);
    bus.i_prev  = p;
    bus.i_next  = n;
    bus.i_clear = c;
    @(posedge clk);
    model_step(v, val, p, n, c);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_value = 4'd0;
    bus.i_prev  = 1'b0;
    bus.i_next  = 1'b0;
    bus.i_clear = 1'b0;
    rst = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill and read back.
    apply(1'b1, 3, 1'b0, 1'b0, 1'b0);
    check_all("fill3");
    apply(1'b1, 6, 1'b0, 1'b0, 1'b0);
    check_all("fill6");
    apply(1'b1, 12, 1'b0, 1'b0, 1'b0);
    check_all("fill12");
    chk("fill.const_value", 32'(bus.o_value), 32'd12);
    chk("fill.const_count", 32'(bus.o_count), 32'd3);

    // Browse to the oldest entry, hold there, then return to live.
    apply(1'b0, 0, 1'b1, 1'b0, 1'b0); check_all("prev1");
    apply(1'b0, 0, 1'b1, 1'b0, 1'b0); check_all("prev2");
    apply(1'b0, 0, 1'b1, 1'b0, 1'b0); check_all("prev3_hold");
    chk("browse.const_value", 32'(bus.o_value), 32'd3);
    chk("browse.const_index", 32'(bus.o_index), 32'd2);
    apply(1'b0, 0, 1'b0, 1'b1, 1'b0); check_all("next1");
    apply(1'b0, 0, 1'b0, 1'b1, 1'b0); check_all("next2_live");
    chk("live.const_value", 32'(bus.o_value), 32'd12);
    apply(1'b0, 0, 1'b0, 1'b1, 1'b0); check_all("next_in_live");

    // Wrap and overwrite: 10 writes into 8 slots.
    apply(1'b0, 0, 1'b0, 1'b0, 1'b1); check_all("clear0");
    for (int i = 1; i <= 10; i++) begin
      apply(1'b1, i, 1'b0, 1'b0, 1'b0);
      check_all("wrap_wr");
    end
    chk("wrap.const_count", 32'(bus.o_count), 32'd8);
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, 0, 1'b1, 1'b0, 1'b0);
      check_all("wrap_prev");
    end
    chk("wrap.const_value", 32'(bus.o_value), 32'd3);
    chk("wrap.const_index", 32'(bus.o_index), 32'd7);
    apply(1'b0, 0, 1'b1, 1'b0, 1'b0); check_all("wrap_prev_hold");

    // Collisions: valid beats prev, then clear beats valid.
    apply(1'b0, 0, 1'b0, 1'b0, 1'b1); check_all("clear1");
    apply(1'b1, 5, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 7, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 11, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 0, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 0, 1'b1, 1'b0, 1'b0); check_all("coll_idx2");
    apply(1'b1, 9, 1'b1, 1'b0, 1'b0); check_all("coll_valid_prev");
    chk("coll.const_value", 32'(bus.o_value), 32'd9);
    apply(1'b0, 0, 1'b1, 1'b1, 1'b0); check_all("coll_prev_next");
    apply(1'b1, 4, 1'b0, 1'b0, 1'b1); check_all("coll_valid_clear");
    chk("coll.const_count", 32'(bus.o_count), 32'd0);

    // prev with too few entries is ignored.
    apply(1'b0, 0, 1'b1, 1'b0, 1'b0); check_all("prev_cnt0");
    apply(1'b1, 8, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 0, 1'b1, 1'b0, 1'b0); check_all("prev_cnt1");

    // Asynchronous reset in the middle of a browse.
    apply(1'b1, 2, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 0, 1'b1, 1'b0, 1'b0); check_all("pre_async");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    apply(1'b1, 13, 1'b0, 1'b0, 1'b0); check_all("post_rst");

    // Random traffic, including multi-cycle pulses and simultaneous events.
    for (int i = 0; i < 400; i++) begin
      bit v, p, n, c;
      int val;
      v   = ($urandom_range(0, 99) < 25);
      p   = ($urandom_range(0, 99) < 35);
      n   = ($urandom_range(0, 99) < 35);
      c   = ($urandom_range(0, 99) < 3);
      val = int'($urandom_range(0, 15));
      apply(v, val, p, n, c);
      check_all("rand");
    end
    idle();
    check_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
